// File: rtl/mux_arb_pipe.sv
// rtl/mux_arb_pipe.sv - N-input valid/ready selector with fixed-select or round-robin grant and a registered output stage
//
// Ports:
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   in_data[N*WIDTH]     channel i at bits [i*WIDTH +: WIDTH]
//   in_valid[N]          per-channel valid
//   in_last[N]           end-of-burst marker (only with MUX_ARB_LOCK_EN)
//   in_ready[N]          per-channel ready, combinational
//   mode                 0 = fixed select via sel, 1 = round-robin
//   sel[SELW]            channel index used in mode 0
//   flush                synchronous clear of output stage, pointer and lock
//   out_data/out_src     registered beat and its source channel
//   out_valid/out_ready  registered valid, downstream ready
//
// Optional feature macro: MUX_ARB_LOCK_EN (round-robin burst lock on in_last)

module mux_arb_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
`ifdef MUX_ARB_LOCK_EN
  input  logic [N-1:0]       in_last,
`endif
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic               flush,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_src,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SELW-1:0]  ptr;
  logic [N-1:0]     grant;
  logic             can_accept;
  logic             xfer;
  logic [SELW-1:0]  gidx;
  logic [SELW-1:0]  ptr_next;
  logic [WIDTH-1:0] gdata;
`ifdef MUX_ARB_LOCK_EN
  logic             lock;
  logic             glast;
`endif

  // Grant vector, at most one bit set.
  always_comb begin
    logic found;
    int   pos;
    grant = '0;
    found = 1'b0;
    pos   = 0;
    if (!mode) begin
      // An out-of-range sel matches no channel, so nothing is granted.
      for (int i = 0; i < N; i++) begin
        grant[i] = (int'(sel) == i);
      end
    end else begin
      // Search ptr, ptr+1, ... wrapping modulo N; first valid wins.
      for (int k = 0; k < N; k++) begin
        pos = int'(ptr) + k;
        if (pos >= N) pos = pos - N;
        for (int i = 0; i < N; i++) begin
          if (!found && pos == i && in_valid[i]) begin
            grant[i] = 1'b1;
            found    = 1'b1;
          end
        end
      end
`ifdef MUX_ARB_LOCK_EN
      // While a burst is open, out_src still holds the locked channel since
      // only that channel can have transferred since the lock was taken.
      if (lock) begin
        for (int i = 0; i < N; i++) begin
          grant[i] = (int'(out_src) == i);
        end
      end
`endif
    end
  end

  assign can_accept = !out_valid || out_ready;
  assign in_ready   = grant & {N{can_accept && !flush}};
  assign xfer       = |(in_ready & in_valid);

  // Index and payload of the granted channel.
  always_comb begin
    gidx  = '0;
    gdata = '0;
`ifdef MUX_ARB_LOCK_EN
    glast = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        gidx  = SELW'(i);
        gdata = in_data[i*WIDTH +: WIDTH];
`ifdef MUX_ARB_LOCK_EN
        glast = in_last[i];
`endif
      end
    end
  end

  // Explicit wrap so non-power-of-two N never lands on an unused index.
  assign ptr_next = (int'(gidx) == N - 1) ? '0 : gidx + SELW'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
`ifdef MUX_ARB_LOCK_EN
      lock      <= 1'b0;
`endif
    end else if (flush) begin
      out_valid <= 1'b0;
      ptr       <= '0;
`ifdef MUX_ARB_LOCK_EN
      lock      <= 1'b0;
`endif
    end else begin
      if (xfer) begin
        // A new beat overwrites any beat draining this cycle: no bubble.
        out_data  <= gdata;
        out_src   <= gidx;
        out_valid <= 1'b1;
        if (mode) begin
`ifdef MUX_ARB_LOCK_EN
          if (!glast) begin
            lock <= 1'b1;
          end else begin
            lock <= 1'b0;
            ptr  <= ptr_next;
          end
`else
          ptr <= ptr_next;
`endif
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
`ifdef MUX_ARB_LOCK_EN
      if (!mode) lock <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_mux_arb_pipe.sv
// tb/tb_mux_arb_pipe.sv - directed scoreboard bench for mux_arb_pipe (N=4 and N=5 instances)

module tb_mux_arb_pipe;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  src;
  } beat_t;

  logic         clk = 1'b0;
  logic         resetn;
  logic         flush;

  logic [127:0] a_in_data;
  logic [3:0]   a_in_valid;
  logic [3:0]   a_in_ready;
  logic         a_mode;
  logic [1:0]   a_sel;
  logic [31:0]  a_out_data;
  logic [1:0]   a_out_src;
  logic         a_out_valid;
  logic         a_out_ready;

  logic [159:0] b_in_data;
  logic [4:0]   b_in_valid;
  logic [4:0]   b_in_ready;
  logic         b_mode;
  logic [2:0]   b_sel;
  logic [31:0]  b_out_data;
  logic [2:0]   b_out_src;
  logic         b_out_valid;
  logic         b_out_ready;

`ifdef MUX_ARB_LOCK_EN
  logic [3:0]   a_in_last;
  logic [4:0]   b_in_last;
`endif

  beat_t sb[$];
  int    n_cmp = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  mux_arb_pipe #(.WIDTH(32), .N(4), .SELW(2)) u_a (
    .clk(clk), .resetn(resetn), .in_data(a_in_data), .in_valid(a_in_valid),
`ifdef MUX_ARB_LOCK_EN
    .in_last(a_in_last),
`endif
    .in_ready(a_in_ready), .mode(a_mode), .sel(a_sel), .flush(flush),
    .out_data(a_out_data), .out_src(a_out_src), .out_valid(a_out_valid),
    .out_ready(a_out_ready)
  );

  mux_arb_pipe #(.WIDTH(32), .N(5), .SELW(3)) u_b (
    .clk(clk), .resetn(resetn), .in_data(b_in_data), .in_valid(b_in_valid),
`ifdef MUX_ARB_LOCK_EN
    .in_last(b_in_last),
`endif
    .in_ready(b_in_ready), .mode(b_mode), .sel(b_sel), .flush(1'b0),
    .out_data(b_out_data), .out_src(b_out_src), .out_valid(b_out_valid),
    .out_ready(b_out_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic [31:0] base);
    for (int i = 0; i < 4; i++) a_in_data[i*32 +: 32] = base | 32'(i);
  endtask

  task automatic push(input logic [31:0] base, input int ch);
    beat_t e;
    e.data = base | 32'(ch);
    e.src  = 2'(ch);
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    beat_t e;
    check({tag, ".valid"}, a_out_valid, 1'b1);
    n_cmp++;
    assert (sb.size() != 0) else begin
      n_err++;
      $error("FAIL %s.sb observed=empty expected=beat", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, ".data"}, a_out_data, e.data);
      check({tag, ".src"}, a_out_src, e.src);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; flush = 1'b0;
    a_in_data = '0; a_in_valid = '0; a_mode = 1'b0; a_sel = '0; a_out_ready = 1'b1;
    b_in_valid = '0; b_mode = 1'b0; b_sel = '0; b_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) b_in_data[i*32 +: 32] = 32'hB0B0_0000 | 32'(i);
`ifdef MUX_ARB_LOCK_EN
    a_in_last = 4'b1111; b_in_last = 5'b11111;
`endif
    step(); step();
    check("rst.valid", a_out_valid, 1'b0);
    check("rst.data", a_out_data, 32'h0);
    check("rst.src", a_out_src, 2'd0);
    resetn = 1'b1;
    step();

    // Fixed select, sel=2
    set_a(32'hA5A5_0000);
    a_mode = 1'b0; a_sel = 2'd2; a_in_valid = 4'b1111;
    #1;
    check("t1.in_ready", a_in_ready, 4'b0100);
    push(32'hA5A5_0000, 2);
    step();
    pop_check("t1");
    a_in_valid = 4'b0000;
    step();
    check("t1.drain", a_out_valid, 1'b0);

    // Round-robin, all valid, back-to-back
    set_a(32'h1111_0000);
    a_mode = 1'b1; a_in_valid = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("t2.in_ready", a_in_ready, 4'b0001 << (c % 4));
      push(32'h1111_0000, c % 4);
      step();
      pop_check("t2");
    end
    a_in_valid = 4'b0000;
    step();
    check("t2.drain", a_out_valid, 1'b0);

    // Stall: pointer is at 2, so ch0 wins among {0,1}
    set_a(32'h2222_0000);
    a_in_valid = 4'b0011;
    #1;
    check("t3.in_ready0", a_in_ready, 4'b0001);
    push(32'h2222_0000, 0);
    step();
    pop_check("t3.first");
    a_out_ready = 1'b0;
    set_a(32'h2929_0000);
    #1;
    check("t3.stall_rdy", a_in_ready, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      step();
      check("t3.hold_valid", a_out_valid, 1'b1);
      check("t3.hold_data", a_out_data, 32'h2222_0000);
      check("t3.hold_rdy", a_in_ready, 4'b0000);
    end
    a_out_ready = 1'b1;
    #1;
    check("t3.resume_rdy", a_in_ready, 4'b0010);
    push(32'h2929_0000, 1);
    step();
    pop_check("t3.resume");
    a_in_valid = 4'b0000;
    step();
    check("t3.drain", a_out_valid, 1'b0);

    // Flush with a beat held and ch1 waiting; pointer goes 2 -> 1 first
    set_a(32'h3333_0000);
    a_in_valid = 4'b0001;
    #1;
    check("t4.in_ready0", a_in_ready, 4'b0001);
    push(32'h3333_0000, 0);
    step();
    pop_check("t4.pre");
    a_in_valid = 4'b0010; flush = 1'b1;
    #1;
    check("t4.flush_rdy", a_in_ready, 4'b0000);
    step();
    flush = 1'b0;
    check("t4.flushed", a_out_valid, 1'b0);
    a_in_valid = 4'b1111;
    #1;
    check("t4.ptr0", a_in_ready, 4'b0001);
    a_in_valid = 4'b0010;
    #1;
    check("t4.ch1_rdy", a_in_ready, 4'b0010);
    push(32'h3333_0000, 1);
    step();
    pop_check("t4.ch1");
    a_in_valid = 4'b0000;
    step();
    check("t4.drain", a_out_valid, 1'b0);

    // N=5: sel=5 is out of range; then sel=4, then asynchronous reset
    b_sel = 3'd5; b_in_valid = 5'b11111;
    #1;
    check("t5.bad_rdy", b_in_ready, 5'b00000);
    step();
    check("t5.bad_valid0", b_out_valid, 1'b0);
    step();
    check("t5.bad_valid1", b_out_valid, 1'b0);
    b_sel = 3'd4; b_out_ready = 1'b0;
    a_in_valid = 4'b1111;
    #1;
    check("t5.sel4_rdy", b_in_ready, 5'b10000);
    step();
    b_in_valid = 5'b00000;
    check("t5.sel4_valid", b_out_valid, 1'b1);
    check("t5.sel4_data", b_out_data, 32'hB0B0_0004);
    check("t5.sel4_src", b_out_src, 3'd4);
    check("t5.a_valid", a_out_valid, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    check("t5.arst_a_valid", a_out_valid, 1'b0);
    check("t5.arst_a_data", a_out_data, 32'h0);
    check("t5.arst_a_src", a_out_src, 2'd0);
    check("t5.arst_b_valid", b_out_valid, 1'b0);
    check("t5.arst_b_data", b_out_data, 32'h0);
    check("t5.arst_b_src", b_out_src, 3'd0);
    a_in_valid = 4'b0000;
    step();
    resetn = 1'b1;
    step();

`ifdef MUX_ARB_LOCK_EN
    // Burst lock: ch1 sends last=0,0,1 while ch2 waits
    a_mode = 1'b1; a_in_valid = 4'b0110; a_in_last = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      set_a(32'h4000_0000 + 32'(c) * 32'h0001_0000);
      if (c == 2) a_in_last = 4'b0010;
      #1;
      check("t6.lock_rdy", a_in_ready, 4'b0010);
      push(32'h4000_0000 + 32'(c) * 32'h0001_0000, 1);
      step();
      pop_check("t6.burst");
    end
    a_in_last = 4'b1111;
    #1;
    check("t6.after_rdy", a_in_ready, 4'b0100);
    push(32'h4002_0000, 2);
    step();
    pop_check("t6.ch2");
    a_in_valid = 4'b0000;
    step();
`endif

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL sb_empty observed=%0d expected=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
